// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state encodings and helpers for the uart_fifo peripheral.
// Holds register word addresses, status-register bit positions, TX/RX FSM enums,
// the minimum baud divisor and the divisor clamp function.
package uart_pkg;

    // Word addresses on the memory bus
    localparam logic [3:0] REG_DATA = 4'd0;
    localparam logic [3:0] REG_STAT = 4'd1;
    localparam logic [3:0] REG_MS   = 4'd2;
    localparam logic [3:0] REG_DIV  = 4'd3;

    // Status register bit positions
    localparam int ST_TX_IDLE  = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_RX_FERR  = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_IS_SIM   = 6;
    localparam int ST_RX_CNT   = 8;   // 8-bit field
    localparam int ST_TX_CNT   = 16;  // 8-bit field

    // Control register (write to REG_STAT) bit positions
    localparam int CTL_RX_POP  = 0;
    localparam int CTL_CLR     = 1;

    // Below 4 cycles/bit the RX half-bit start qualification degenerates
    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// uart_fifo_if: CPU memory-bus port of the uart_fifo peripheral.
// Ports: m_sel (block select), m_addr (word address), m_data_i (write data),
//        m_data_o (read data), m_rd (level read qualifier), m_wr (write strobe).
interface uart_fifo_if;
    import uart_pkg::*;

    logic        m_sel;
    logic [3:0]  m_addr;
    logic [31:0] m_data_i;
    logic [31:0] m_data_o;
    logic        m_rd;
    logic        m_wr;

    modport master (output m_sel, m_addr, m_data_i, m_rd, m_wr, input m_data_o);
    modport slave  (input m_sel, m_addr, m_data_i, m_rd, m_wr, output m_data_o);

endinterface

// File: rtl/uart_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through head.
// Latency: a pushed word is visible on head_o the cycle after the push edge.
// Backpressure: push is dropped when full (judged before any same-cycle pop); pop is ignored when empty.
// Ports: clk_96mhz/rstn, push_i + push_dat_i, pop_i, head_o, full_o, empty_o, count_o.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_96mhz,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk_96mhz) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: contents are only observed through valid pointers
    always_ff @(posedge clk_96mhz) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: buffered 8N1 UART (TX/RX FIFOs), sticky error flags, ms counter, programmable baud divisor.
// Latency: reads are combinational; TXD falls 2 cycles after a push into an idle TX path; rx_valid within 3 cycles of stop sample.
// Backpressure: none on the bus; TX push to full FIFO drops and sets tx_ovf, RX byte into full FIFO drops and sets rx_ovf.
// Ports: clk_96mhz, rstn (sync, active-low), bus_if (memory-bus slave), RXD (async serial in), TXD (serial out, idle high).
module uart_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 96,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16,
    parameter int MS_DIV   = 96000
) (
    input  logic       clk_96mhz,
    input  logic       rstn,
    uart_fifo_if.slave bus_if,
    input  logic       RXD,
    output logic       TXD
);

`ifdef __ICARUS__
    localparam logic IS_SIM = 1'b1;
`else
    localparam logic IS_SIM = 1'b0;
`endif

    localparam logic [31:0] MS_LAST = 32'(MS_DIV - 1);

    // ---------------------------------------------------------------- bus decode
    logic wr_en, wr_data, wr_stat, wr_ms, wr_div;
    logic flag_clr, rx_pop;

    assign wr_en    = bus_if.m_sel & bus_if.m_wr;
    assign wr_data  = wr_en & (bus_if.m_addr == REG_DATA);
    assign wr_stat  = wr_en & (bus_if.m_addr == REG_STAT);
    assign wr_ms    = wr_en & (bus_if.m_addr == REG_MS);
    assign wr_div   = wr_en & (bus_if.m_addr == REG_DIV);
    assign flag_clr = wr_stat & bus_if.m_data_i[CTL_CLR];
    assign rx_pop   = wr_stat & bus_if.m_data_i[CTL_RX_POP];

    // The read qualifier is a level, so reads are side-effect free and it is not needed
    logic unused_ok;
    assign unused_ok = bus_if.m_rd;

    // ---------------------------------------------------------------- FIFOs
    logic [7:0]                   tx_head, rx_head;
    logic                         tx_full, tx_empty, rx_full, rx_empty;
    logic [$clog2(TX_DEPTH):0]    tx_count;
    logic [$clog2(RX_DEPTH):0]    rx_count;
    logic                         tx_pop, rx_push;
    logic [7:0]                   rx_shift_q;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_96mhz  (clk_96mhz),
        .rstn       (rstn),
        .push_i     (wr_data),
        .push_dat_i (bus_if.m_data_i[7:0]),
        .pop_i      (tx_pop),
        .head_o     (tx_head),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .count_o    (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_96mhz  (clk_96mhz),
        .rstn       (rstn),
        .push_i     (rx_push),
        .push_dat_i (rx_shift_q),
        .pop_i      (rx_pop),
        .head_o     (rx_head),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .count_o    (rx_count)
    );

    // ---------------------------------------------------------------- baud divisor
    logic [15:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (wr_div) div_d = clamp_div(bus_if.m_data_i[15:0]);
    end

    always_ff @(posedge clk_96mhz) begin
        if (!rstn) div_q <= 16'(BAUD_DIV);
        else       div_q <= div_d;
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] tx_div_q;     // divisor frozen for the frame in flight
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        txd_q;
    logic        tx_tick;

    assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);

    // Fetch at IDLE, or at the last STOP cycle so consecutive frames abut
    always_comb begin
        tx_pop = 1'b0;
        if (!tx_empty) begin
            if (tx_state_q == TX_IDLE)              tx_pop = 1'b1;
            if (tx_state_q == TX_STOP && tx_tick)   tx_pop = 1'b1;
        end
    end

    // txd_q is a registered decode of the current state, so the line trails the state by one cycle
    always_ff @(posedge clk_96mhz) begin
        if (!rstn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(BAUD_DIV);
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_pop) begin
                        tx_shift_q <= tx_head;
                        tx_div_q   <= div_q;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    txd_q <= 1'b0;
                    if (tx_tick) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    txd_q <= tx_shift_q[0];
                    if (tx_tick) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) tx_state_q <= TX_STOP;
                        else                  tx_bit_q   <= tx_bit_q + 3'd1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    txd_q <= 1'b1;
                    if (tx_tick) begin
                        tx_cnt_q <= '0;
                        if (tx_pop) begin
                            tx_shift_q <= tx_head;
                            tx_div_q   <= div_q;
                            tx_state_q <= TX_START;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TXD = txd_q;

    // ---------------------------------------------------------------- RX FSM
    logic        rxd_s1_q, rxd_s2_q;
    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [15:0] rx_div_q;
    logic [2:0]  rx_bit_q;
    logic        rx_tick, rx_half_tick, rx_stop_smp;

    assign rx_tick      = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_half_tick = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);
    assign rx_stop_smp  = (rx_state_q == RX_STOP) && rx_tick;

    // Framing error takes priority: a bad frame is never counted as an overrun
    assign rx_push = rx_stop_smp & rxd_s2_q & ~rx_full;

    always_ff @(posedge clk_96mhz) begin
        if (!rstn) begin
            rxd_s1_q   <= 1'b1;
            rxd_s2_q   <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(BAUD_DIV);
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rxd_s1_q <= RXD;
            rxd_s2_q <= rxd_s1_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rxd_s2_q) begin
                        rx_div_q   <= div_q;
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                // Low must persist half a bit; afterwards sampling lands on bit centres
                RX_START: begin
                    if (rxd_s2_q) begin
                        rx_state_q <= RX_IDLE;
                    end else if (rx_half_tick) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rxd_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- sticky flags
    logic rx_ovf_q, rx_ferr_q, tx_ovf_q;
    logic rx_ovf_d, rx_ferr_d, tx_ovf_d;

    // Set terms are OR-ed after the clear so a same-cycle set survives
    always_comb begin
        rx_ovf_d  = (rx_ovf_q  & ~flag_clr) | (rx_stop_smp & rxd_s2_q & rx_full);
        rx_ferr_d = (rx_ferr_q & ~flag_clr) | (rx_stop_smp & ~rxd_s2_q);
        tx_ovf_d  = (tx_ovf_q  & ~flag_clr) | (wr_data & tx_full);
    end

    always_ff @(posedge clk_96mhz) begin
        if (!rstn) begin
            rx_ovf_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
        end else begin
            rx_ovf_q  <= rx_ovf_d;
            rx_ferr_q <= rx_ferr_d;
            tx_ovf_q  <= tx_ovf_d;
        end
    end

    // ---------------------------------------------------------------- ms counter
    logic [31:0] ms_timer_q, ms_timer_d;
    logic [31:0] ms_counter_q, ms_counter_d;

    always_comb begin
        ms_timer_d   = ms_timer_q + 32'd1;
        ms_counter_d = ms_counter_q;
        if (wr_ms) begin
            ms_timer_d   = '0;
            ms_counter_d = bus_if.m_data_i;
        end else if (ms_timer_q == MS_LAST) begin
            ms_timer_d   = '0;
            ms_counter_d = ms_counter_q + 32'd1;
        end
    end

    always_ff @(posedge clk_96mhz) begin
        if (!rstn) begin
            ms_timer_q   <= '0;
            ms_counter_q <= '0;
        end else begin
            ms_timer_q   <= ms_timer_d;
            ms_counter_q <= ms_counter_d;
        end
    end

    // ---------------------------------------------------------------- read mux
    logic [31:0] rd_dat;

    always_comb begin
        rd_dat = '0;
        if (bus_if.m_sel) begin
            case (bus_if.m_addr)
                REG_DATA: rd_dat = {23'b0, ~rx_empty, rx_head};
                REG_STAT: begin
                    rd_dat[ST_TX_IDLE]      = tx_empty & (tx_state_q == TX_IDLE);
                    rd_dat[ST_RX_VALID]     = ~rx_empty;
                    rd_dat[ST_TX_FULL]      = tx_full;
                    rd_dat[ST_RX_OVF]       = rx_ovf_q;
                    rd_dat[ST_RX_FERR]      = rx_ferr_q;
                    rd_dat[ST_TX_OVF]       = tx_ovf_q;
                    rd_dat[ST_IS_SIM]       = IS_SIM;
                    rd_dat[ST_RX_CNT +: 8]  = 8'(rx_count);
                    rd_dat[ST_TX_CNT +: 8]  = 8'(tx_count);
                end
                REG_MS:   rd_dat = ms_counter_q;
                REG_DIV:  rd_dat = {16'b0, div_q};
                default:  rd_dat = '0;
            endcase
        end
    end

    assign bus_if.m_data_o = rd_dat;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed self-checking bench for uart_fifo.
// MS_DIV is shortened to 1000 so the millisecond wrap fits a short run;
// the FIFO-fill scenarios run at div=8 for the same reason.
module tb_uart_fifo;
    import uart_pkg::*;

`ifdef __ICARUS__
    localparam logic [31:0] SIM = 32'h40;
`else
    localparam logic [31:0] SIM = 32'h0;
`endif

    logic clk_96mhz = 1'b0;
    logic rstn;
    logic RXD;
    logic TXD;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    uart_fifo_if bus();

    uart_fifo #(.BAUD_DIV(96), .TX_DEPTH(16), .RX_DEPTH(16), .MS_DIV(1000)) dut (
        .clk_96mhz (clk_96mhz),
        .rstn      (rstn),
        .bus_if    (bus),
        .RXD       (RXD),
        .TXD       (TXD)
    );

    always #5 clk_96mhz = ~clk_96mhz;
    always @(posedge clk_96mhz) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One write per call; the write lands on the posedge between the two negedges
    task automatic bus_wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk_96mhz);
        bus.m_sel    = 1'b1;
        bus.m_wr     = 1'b1;
        bus.m_addr   = a;
        bus.m_data_i = v;
        @(negedge clk_96mhz);
        bus.m_sel    = 1'b0;
        bus.m_wr     = 1'b0;
    endtask

    // Zero-wait read, done mid-cycle without consuming an edge
    task automatic bus_rd(input logic [3:0] a, output logic [31:0] v);
        bus.m_sel  = 1'b1;
        bus.m_rd   = 1'b1;
        bus.m_addr = a;
        #1;
        v = bus.m_data_o;
        bus.m_sel  = 1'b0;
        bus.m_rd   = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_96mhz);
            RXD = fr[k];
            repeat (div - 1) @(negedge clk_96mhz);
        end
        @(negedge clk_96mhz);
        RXD = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [9:0]  fr;
        int          c0;

        rstn = 1'b0; RXD = 1'b1;
        bus.m_sel = 1'b0; bus.m_addr = '0; bus.m_data_i = '0; bus.m_rd = 1'b0; bus.m_wr = 1'b0;
        repeat (3) @(negedge clk_96mhz);
        rstn = 1'b1;
        @(negedge clk_96mhz);

        // ---- reset state
        bus_rd(REG_STAT, d); chk("rst_stat", d, 32'h1 | SIM);
        chk("rst_txd", 32'(TXD), 32'd1);
        bus_rd(REG_DIV, d);  chk("rst_div", d, 32'd96);
        bus_rd(REG_MS, d);   chk("rst_ms", d, 32'd0);
        bus_rd(4'd7, d);     chk("unmapped", d, 32'd0);
        bus.m_sel = 1'b0; bus.m_addr = REG_DIV; #1;
        chk("nosel", bus.m_data_o, 32'd0);

        // ---- TX 0x55 at div=96: start edge exactly 2 cycles after the write edge
        bus_wr(REG_DATA, 32'h55);
        @(negedge clk_96mhz); chk("tx_lat_e1", 32'(TXD), 32'd1);
        @(negedge clk_96mhz); chk("tx_lat_e2", 32'(TXD), 32'd0);
        fr = {1'b1, 8'h55, 1'b0};
        repeat (48) @(negedge clk_96mhz);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (96) @(negedge clk_96mhz);
            chk($sformatf("tx55_bit%0d", k), 32'(TXD), 32'(fr[k]));
        end
        repeat (46) @(negedge clk_96mhz);
        bus_rd(REG_STAT, d); chk("tx_busy_e960", d, 32'h0 | SIM);
        @(negedge clk_96mhz);
        bus_rd(REG_STAT, d); chk("tx_idle_e961", d, 32'h1 | SIM);

        // ---- RX 0xA3 at div=96
        send_rx(8'hA3, 1'b1, 96);
        repeat (2) @(negedge clk_96mhz);
        bus_rd(REG_DATA, d); chk("rx_a3_data", d, 32'h1A3);
        bus_rd(REG_STAT, d); chk("rx_a3_stat", d, 32'h103 | SIM);
        bus_wr(REG_STAT, 32'h1);
        bus_rd(REG_STAT, d); chk("rx_a3_popped", d, 32'h1 | SIM);

        // ---- divisor clamp and load
        bus_wr(REG_DIV, 32'd2);
        bus_rd(REG_DIV, d); chk("div_clamp", d, 32'd4);
        bus_wr(REG_DIV, 32'd8);
        bus_rd(REG_DIV, d); chk("div_8", d, 32'd8);

        // ---- TX overflow: byte 0 goes straight to the shifter, 16 fill the FIFO, the 18th is dropped
        for (int i = 0; i < 18; i++) begin
            bus_wr(REG_DATA, 32'(8'(8'h10 + i)));
            if (i == 0) c0 = cyc;
        end
        bus_rd(REG_STAT, d); chk("tx_ovf_stat", d, 32'h0010_0024 | SIM);
        // 17 abutting 80-cycle frames: idle first seen 1 + 17*80 cycles after the first write edge
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_96mhz);
            bus_rd(REG_STAT, d);
            if (d[ST_TX_IDLE]) break;
        end
        chk("tx_b2b_cycles", 32'(cyc - c0), 32'd1361);
        bus_wr(REG_STAT, 32'h2);
        bus_rd(REG_STAT, d); chk("tx_ovf_clr", d, 32'h1 | SIM);

        // ---- RX overflow at div=8: 17 frames, the 17th is lost
        for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1, 8);
        repeat (2) @(negedge clk_96mhz);
        bus_rd(REG_STAT, d); chk("rx_ovf_stat", d, 32'h100B | SIM);
        bus_rd(REG_DATA, d); chk("rx_ovf_head", d, 32'h140);
        send_rx(8'h77, 1'b0, 8);
        repeat (2) @(negedge clk_96mhz);
        bus_rd(REG_STAT, d); chk("rx_ferr_stat", d, 32'h101B | SIM);
        for (int i = 0; i < 16; i++) begin
            bus_rd(REG_DATA, d);
            chk($sformatf("rx_pop%0d", i), d, 32'h140 + 32'(i));
            bus_wr(REG_STAT, 32'h1);
        end
        bus_rd(REG_STAT, d); chk("rx_drained", d, 32'h19 | SIM);
        bus_wr(REG_STAT, 32'h1);
        bus_rd(REG_STAT, d); chk("rx_pop_empty", d, 32'h19 | SIM);
        bus_wr(REG_STAT, 32'h2);
        bus_rd(REG_STAT, d); chk("rx_flags_clr", d, 32'h1 | SIM);

        // ---- ms counter: load 5, wrap after MS_DIV=1000 cycles
        bus_wr(REG_MS, 32'd5);
        repeat (999) @(negedge clk_96mhz);
        bus_rd(REG_MS, d); chk("ms_before_wrap", d, 32'd5);
        @(negedge clk_96mhz);
        bus_rd(REG_MS, d); chk("ms_after_wrap", d, 32'd6);

        // ---- reset mid-frame with a byte still queued
        bus_wr(REG_DATA, 32'h00);
        bus_wr(REG_DATA, 32'h00);
        chk("mid_txd_low", 32'(TXD), 32'd0);
        rstn = 1'b0;
        @(negedge clk_96mhz);
        chk("mid_rst_txd", 32'(TXD), 32'd1);
        bus_rd(REG_STAT, d); chk("mid_rst_stat", d, 32'h1 | SIM);
        bus_rd(REG_DIV, d);  chk("mid_rst_div", d, 32'd96);
        rstn = 1'b1;
        @(negedge clk_96mhz);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
